overlap_window_addr_gen: RTL and testbench
==========================================

Name: overlap_window_addr_gen

Overview:
- Address generator for a circular sample buffer (external dual-port RAM) that feeds overlapped analysis windows to the STFT/pitch-shift datapath.
- Generalises the fixed 2x-overlap window FIFO manager:
  - window length and buffer depth are independent parameters;
  - overlap factor is run-time selectable (1x/2x/4x/8x);
  - provides occupancy plus window start/last flags for the window-function LUT and the FFT framer.

Parameters:
- ADDRWIDTH, 12: buffer depth DEPTH = 2^ADDRWIDTH samples; write_addr/read_addr width.
- WINLOG2, 11: window length WIN = 2^WINLOG2. Must satisfy 1 <= WINLOG2 <= ADDRWIDTH; elaboration error otherwise.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- enqueue  in  1  request to write one sample at write_addr
- dequeue  in  1  request to read one sample at read_addr
- ovl_sel  in  2  hop = WIN >> ovl_sel (0:1x/no overlap, 1:2x, 2:4x, 3:8x)
- full  out  1  enqueue would overwrite a sample still needed
- empty  out  1  no unread sample available for the current window position
- write_addr  out  ADDRWIDTH  RAM write address
- read_addr  out  ADDRWIDTH  RAM read address
- window_idx  out  WINLOG2  index of read_addr sample within current window (window LUT address)
- window_start  out  1  window_idx == 0
- window_last  out  1  window_idx == WIN-1
- level  out  ADDRWIDTH+1  retained samples, enq_ptr - rd_base (0..DEPTH)

Behaviour:
- State: enq_ptr, rd_base (ADDRWIDTH+1 bits each, modulo 2^(ADDRWIDTH+1)); rd_off (WINLOG2 bits); hop_q (WINLOG2+1 bits).
- Address outputs:
  - write_addr = enq_ptr[ADDRWIDTH-1:0];
  - read_addr = (rd_base + rd_off)[ADDRWIDTH-1:0];
  - window_idx = rd_off.
- Flags (combinational from registers; zero-latency flags, addresses valid in the same cycle):
  - full = (level == DEPTH);
  - empty = (enq_ptr == rd_base + rd_off), computed at ADDRWIDTH+1 width.
- Hop:
  - hop_q = WIN >> min(ovl_sel, WINLOG2); minimum hop is 1.
  - Loaded at reset and on every window completion.
  - A change of ovl_sel takes effect only for the window after the one in progress.
- Accepted enqueue (enqueue && !full): enq_ptr += 1.
- Accepted dequeue (dequeue && !empty):
  - if rd_off != WIN-1: rd_off += 1;
  - else (window completion): rd_off <= 0, rd_base <= rd_base + hop_q, hop_q reloads from ovl_sel.
- Rejected requests (enqueue while full, dequeue while empty) change no state.
- Simultaneous accepted enqueue and dequeue in one cycle: both pointers update independently.
  - full/empty are evaluated from pre-edge state; there is no same-cycle bypass.
  - Dequeue while empty is rejected even if enqueue is accepted in the same cycle.
- Overlap retention:
  - Samples from rd_base upward remain protected until rd_base advances.
  - With hop < WIN, the last WIN-hop samples of a window are re-read in the next window.
  - level drops by hop_q at window completion, not per dequeue.
- Deadlock rule: a window can complete only if WIN <= DEPTH, which the parameter check guarantees.
- Wrap-around: all pointer arithmetic is modulo 2^(ADDRWIDTH+1); addresses are the low ADDRWIDTH bits. Correct across unlimited wraps.
- Reset (any cycle, including mid-window):
  - enq_ptr = rd_base = 0, rd_off = 0, hop_q = f(ovl_sel);
  - outputs: empty=1, full=0, level=0, write_addr=read_addr=0, window_idx=0, window_start=1, window_last=0 (1 only if WINLOG2=0, disallowed).
  - In-flight window is discarded.
- No internal RAM. The consumer registers RAM read data; this block adds no read latency.

Test Plan:
- ADDRWIDTH=4, WINLOG2=3, ovl_sel=1:
  - reset, enqueue 16 samples -> full=1 after the 16th, level=16, 17th enqueue ignored (write_addr stays 0).
  - Dequeue 8 -> read_addr 0..7, window_last=1 on idx 7; afterwards rd_base=4, level=12, full=0, read_addr=4, window_start=1.
- Same config, continuous enqueue/dequeue for 200 samples -> read_addr sequence per window is 0-7, 4-11, 8-15, 12-3 (wrapped), ...; no overwrite (enqueue never accepted while write_addr == rd_base with level=16).
- ovl_sel=0 then 3 switched mid-window -> current window completes with hop 8 (next reads 8..15); the following window uses hop 1.
- Empty stall: enqueue 5 then dequeue 6 times -> 6th dequeue rejected, empty=1, window_idx=5 held. Enqueue 1 -> empty=0, dequeue resumes at read_addr 5.
- Simultaneous enqueue+dequeue at level=16 with rd_off at the last index -> dequeue accepted, enqueue rejected (full pre-edge); next cycle full=0, level=12.
- Reset asserted with level=9, rd_off=3 -> next cycle all outputs at reset values; a following enqueue writes address 0.

Source files
------------

// File: rtl/overlap_window_addr_gen.sv
// Address generator for a circular sample buffer that feeds overlapped
// analysis windows. Window reads restart hop samples after the previous
// window start, so the tail of each window is re-read by the next one.
// Samples from rd_base upward stay protected until the window completes.
module overlap_window_addr_gen #(
   parameter int ADDRWIDTH = 12,
   parameter int WINLOG2   = 11
)(
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enqueue,
   input  logic                 dequeue,
   input  logic [1:0]           ovl_sel,
   output logic                 full,
   output logic                 empty,
   output logic [ADDRWIDTH-1:0] write_addr,
   output logic [ADDRWIDTH-1:0] read_addr,
   output logic [WINLOG2-1:0]   window_idx,
   output logic                 window_start,
   output logic                 window_last,
   output logic [ADDRWIDTH:0]   level
);

   // Pointers carry one extra bit so full (level == DEPTH) and empty differ.
   localparam int             PW    = ADDRWIDTH + 1;
   localparam logic [WINLOG2:0] WIN = {1'b1, {WINLOG2{1'b0}}};
   localparam logic [PW-1:0]  DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

   generate
      if (WINLOG2 < 1 || WINLOG2 > ADDRWIDTH) begin : g_bad_param
         $error("overlap_window_addr_gen: need 1 <= WINLOG2 <= ADDRWIDTH");
      end
   endgenerate

   logic [PW-1:0]      r_enq_ptr;
   logic [PW-1:0]      r_rd_base;
   logic [WINLOG2-1:0] r_rd_off;
   logic [WINLOG2:0]   r_hop_q;

   logic [WINLOG2:0]   w_hop_shift;
   logic [WINLOG2:0]   w_hop_next;
   logic [PW-1:0]      w_rd_ptr;
   logic [PW-1:0]      w_level;
   logic               w_enq_ok;
   logic               w_deq_ok;

   // Hop for the next window; shifting past WINLOG2 would give 0, so clamp to 1.
   always_comb begin
      w_hop_shift = WIN >> ovl_sel;
      w_hop_next  = (w_hop_shift == '0) ? (WINLOG2+1)'(1) : w_hop_shift;
   end

   // Zero-latency flags and addresses straight from the registered pointers.
   always_comb begin
      w_rd_ptr     = r_rd_base + PW'(r_rd_off);
      w_level      = r_enq_ptr - r_rd_base;
      full         = (w_level == DEPTH);
      empty        = (r_enq_ptr == w_rd_ptr);
      write_addr   = r_enq_ptr[ADDRWIDTH-1:0];
      read_addr    = w_rd_ptr[ADDRWIDTH-1:0];
      window_idx   = r_rd_off;
      window_start = (r_rd_off == '0);
      window_last  = (r_rd_off == '1);
      level        = w_level;
      w_enq_ok     = enqueue && !full;
      w_deq_ok     = dequeue && !empty;
   end

   // Pointer updates; a completed window releases hop_q samples and latches the next hop.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_enq_ptr <= '0;
         r_rd_base <= '0;
         r_rd_off  <= '0;
         r_hop_q   <= w_hop_next;
      end else begin
         if (w_enq_ok)
            r_enq_ptr <= r_enq_ptr + PW'(1);
         if (w_deq_ok) begin
            if (window_last) begin
               r_rd_off  <= '0;
               r_rd_base <= r_rd_base + PW'(r_hop_q);
               r_hop_q   <= w_hop_next;
            end else begin
               r_rd_off  <= r_rd_off + WINLOG2'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_overlap_window_addr_gen.sv
// Bench for overlap_window_addr_gen (DEPTH 16, WIN 8). The reference model
// counts samples with unbounded integers and a small sample-id RAM checks
// that every read returns the sample the window schedule calls for.
module tb_overlap_window_addr_gen;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enqueue = 1'b0;
   logic       dequeue = 1'b0;
   logic [1:0] ovl_sel = 2'd1;
   logic       full, empty, window_start, window_last;
   logic [3:0] write_addr, read_addr;
   logic [2:0] window_idx;
   logic [4:0] level;

   overlap_window_addr_gen #(.ADDRWIDTH(4), .WINLOG2(3)) dut (
      .clock(clock), .reset(reset), .enqueue(enqueue), .dequeue(dequeue),
      .ovl_sel(ovl_sel), .full(full), .empty(empty),
      .write_addr(write_addr), .read_addr(read_addr),
      .window_idx(window_idx), .window_start(window_start),
      .window_last(window_last), .level(level)
   );

   always #5 clock = ~clock;

   int n_chk  = 0;
   int n_fail = 0;

   // model: total samples written, index of current window's first sample,
   // position in window, hop latched for the current window
   int m_enq, m_base, m_off, m_hop;
   int tbram [16];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int hopf(input int s);
      return 8 / (1 << s);
   endfunction

   task automatic check_all();
      int lvl;
      lvl = m_enq - m_base;
      chk("write_addr",   write_addr,   m_enq % 16);
      chk("read_addr",    read_addr,    (m_base + m_off) % 16);
      chk("window_idx",   window_idx,   m_off);
      chk("window_start", window_start, m_off == 0);
      chk("window_last",  window_last,  m_off == 7);
      chk("level",        level,        lvl);
      chk("full",         full,         lvl == 16);
      chk("empty",        empty,        m_enq == m_base + m_off);
   endtask

   task automatic do_reset(input int sel);
      reset = 1'b1; enqueue = 1'b0; dequeue = 1'b0; ovl_sel = 2'(sel);
      @(posedge clock);
      m_enq = 0; m_base = 0; m_off = 0; m_hop = hopf(sel);
      #1 reset = 1'b0;
      check_all();
   endtask

   task automatic step(input bit e, input bit d);
      bit         acc_e, acc_d;
      logic [3:0] wa;
      enqueue = e; dequeue = d;
      acc_e = e && (m_enq - m_base) < 16;
      acc_d = d && (m_enq != m_base + m_off);
      wa = write_addr;
      if (acc_d) chk("rd_data", tbram[read_addr], m_base + m_off);
      @(posedge clock);
      if (acc_e) begin
         tbram[wa] = m_enq;
         m_enq++;
      end
      if (acc_d) begin
         if (m_off == 7) begin
            m_off = 0;
            m_base += m_hop;
            m_hop = hopf(int'(ovl_sel));
         end else begin
            m_off++;
         end
      end
      #1;
      check_all();
      enqueue = 1'b0; dequeue = 1'b0;
   endtask

   initial begin
      // fill to full, 17th write ignored
      do_reset(1);
      for (int i = 0; i < 17; i++) step(1, 0);
      chk("fill_full", full, 1);
      chk("fill_wa", write_addr, 0);
      chk("fill_level", level, 16);

      // one window of 8 reads, then base advances by hop 4
      for (int i = 0; i < 8; i++) step(0, 1);
      chk("win1_ra", read_addr, 4);
      chk("win1_level", level, 12);
      chk("win1_start", window_start, 1);

      // mid-window overlap change: current window keeps hop 8, next uses 1
      do_reset(0);
      for (int i = 0; i < 16; i++) step(1, 0);
      for (int i = 0; i < 3; i++) step(0, 1);
      ovl_sel = 2'd3;
      for (int i = 0; i < 5; i++) step(0, 1);
      chk("sw_ra8", read_addr, 8);
      for (int i = 0; i < 8; i++) step(0, 1);
      chk("sw_ra9", read_addr, 9);

      // empty stall and resume
      do_reset(1);
      for (int i = 0; i < 5; i++) step(1, 0);
      for (int i = 0; i < 6; i++) step(0, 1);
      chk("stall_empty", empty, 1);
      chk("stall_idx", window_idx, 5);
      step(1, 0);
      chk("resume_empty", empty, 0);
      chk("resume_ra", read_addr, 5);
      step(0, 1);

      // simultaneous enq+deq while full at last index
      do_reset(1);
      for (int i = 0; i < 16; i++) step(1, 0);
      for (int i = 0; i < 7; i++) step(0, 1);
      step(1, 1);
      chk("sim_level", level, 12);
      chk("sim_full", full, 0);
      chk("sim_wa", write_addr, 0);

      // reset mid-window
      do_reset(1);
      for (int i = 0; i < 9; i++) step(1, 0);
      for (int i = 0; i < 3; i++) step(0, 1);
      do_reset(2);
      chk("rst_wa", write_addr, 0);
      step(1, 0);

      // continuous streaming at 2x overlap, then random traffic and overlap changes
      do_reset(1);
      for (int i = 0; i < 200; i++) step(1, 1);
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 40) == 0) ovl_sel = 2'($urandom_range(0, 3));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      for (int i = 0; i < 300; i++) step($urandom_range(0, 2) == 0, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
